// File: rtl/uart_cfg_pkg.sv
// uart_cfg_pkg -- shared types and helpers for the configurable UART.
//   par_t      : parity mode (PAR_NONE / PAR_EVEN / PAR_ODD)
//   state_t    : frame FSM state, shared by the TX and RX engines
//   DBIT_SEL_* : dbit_sel codes; DBITS_* : the matching data-bit counts
//   dbits_decode / par_decode : turn the raw select inputs into counts/modes
package uart_cfg_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic [1:0] DBIT_SEL_5 = 2'b00;
  localparam logic [1:0] DBIT_SEL_6 = 2'b01;
  localparam logic [1:0] DBIT_SEL_7 = 2'b10;
  localparam logic [1:0] DBIT_SEL_8 = 2'b11;

  localparam logic [3:0] DBITS_5 = 4'd5;
  localparam logic [3:0] DBITS_6 = 4'd6;
  localparam logic [3:0] DBITS_7 = 4'd7;
  localparam logic [3:0] DBITS_8 = 4'd8;

  function automatic logic [3:0] dbits_decode(input logic [1:0] sel);
    case (sel)
      DBIT_SEL_5: return DBITS_5;
      DBIT_SEL_6: return DBITS_6;
      DBIT_SEL_7: return DBITS_7;
      default:    return DBITS_8;
    endcase
  endfunction

  // Code 11 is treated as "no parity", same as 00.
  function automatic par_t par_decode(input logic [1:0] sel);
    case (sel)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_cfg_fifo.sv
// uart_cfg_fifo -- first-word-fall-through FIFO with occupancy output.
//   clk, reset : clock, synchronous active-high reset
//   push/w_data: write request and data (ignored when full unless popping)
//   pop        : remove head (ignored when empty)
//   r_data     : current head, zero while empty
//   empty/full : status; level : entries held, 0 .. 2**ADDR_W
module uart_cfg_fifo #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [WIDTH-1:0]  w_data,
  output logic [WIDTH-1:0]  r_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   level_reg, level_next;
  logic              push_ok, pop_ok;

  assign empty  = (level_reg == '0);
  assign full   = (level_reg == FULL_LVL);
  assign level  = level_reg;

  // A push on a full FIFO is accepted only when a pop frees a slot in the
  // same cycle; a pop on an empty FIFO never happens, so push-only wins there.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Head is read combinationally so the first word is visible immediately.
  assign r_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= w_data;
  end

  always_comb begin
    level_next = level_reg;
    case ({push_ok, pop_ok})
      2'b10:   level_next = level_reg + 1'b1;
      2'b01:   level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Pointers wrap naturally at their width.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/uart_cfg.sv
// uart_cfg -- UART with runtime frame format (5-8 data bits, parity, 1/2 stop)
// and TX/RX FIFOs.
//   clk, reset        : clock, synchronous active-high reset
//   dvsr              : baud divisor, one oversample tick every dvsr+1 clocks
//   dbit_sel, par_sel, stop2 : frame format, latched at each frame start
//   rx / tx           : serial lines, idle high
//   rd_uart, r_data   : pop / head of RX FIFO (FWFT, unused high bits 0)
//   wr_uart, w_data   : push to TX FIFO
//   rx_empty, tx_full, rx_level, tx_level : FIFO status
//   parity_err, frame_err, overrun_err    : sticky flags, cleared by clr_err
// Build option: define UART_CFG_PARITY_EN to enable the parity bit; without it
// par_sel is ignored and parity_err is tied low.
module uart_cfg
  import uart_cfg_pkg::*;
#(
  parameter int FIFO_W  = 4,
  parameter int SB_TICK = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [20:0]       dvsr,
  input  logic [1:0]        dbit_sel,
  input  logic [1:0]        par_sel,
  input  logic              stop2,
  input  logic              rx,
  input  logic              rd_uart,
  input  logic              wr_uart,
  input  logic [7:0]        w_data,
  input  logic              clr_err,
  output logic              tx,
  output logic [7:0]        r_data,
  output logic              rx_empty,
  output logic              tx_full,
  output logic [FIFO_W:0]   rx_level,
  output logic [FIFO_W:0]   tx_level,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun_err
);

  localparam int TW = $clog2(SB_TICK);
  localparam logic [TW-1:0] S_LAST = TW'(SB_TICK - 1);
  localparam logic [TW-1:0] S_HALF = TW'(SB_TICK / 2 - 1);

  // ---------------- baud tick ----------------
  logic [20:0] baud_cnt_reg, baud_cnt_next;
  logic        tick;

  // >= rather than == so a divisor lowered mid-count reloads at once.
  assign tick          = (baud_cnt_reg >= dvsr);
  assign baud_cnt_next = tick ? '0 : baud_cnt_reg + 21'd1;

  always_ff @(posedge clk) begin
    if (reset) baud_cnt_reg <= '0;
    else       baud_cnt_reg <= baud_cnt_next;
  end

  // ---------------- configuration ----------------
  par_t       par_eff;
  logic       parity_err_reg;
  logic [3:0] dbits_ld;
  assign dbits_ld = dbits_decode(dbit_sel);

`ifdef UART_CFG_PARITY_EN
  assign par_eff    = par_decode(par_sel);
  assign parity_err = parity_err_reg;
`else
  logic unused_par;
  assign par_eff    = PAR_NONE;
  assign parity_err = 1'b0;
  assign unused_par = ^{par_sel, parity_err_reg};
`endif

  // ---------------- TX ----------------
  logic       tx_empty, tx_done;
  logic [7:0] tx_head, tx_mask, tx_ld_data;
  logic       tx_ld_pbit;

  uart_cfg_fifo #(.WIDTH(8), .ADDR_W(FIFO_W)) u_tx_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (wr_uart),
    .pop    (tx_done),
    .w_data (w_data),
    .r_data (tx_head),
    .empty  (tx_empty),
    .full   (tx_full),
    .level  (tx_level)
  );

  // Only the selected number of low bits is transmitted.
  for (genvar gi = 0; gi < 8; gi++) begin : g_tx_mask
    assign tx_mask[gi] = (4'(gi) < dbits_ld);
  end
  assign tx_ld_data = tx_head & tx_mask;
  assign tx_ld_pbit = (^tx_ld_data) ^ (par_eff == PAR_ODD);

  state_t     tx_state_reg, tx_state_next;
  logic [TW-1:0] tx_s_reg, tx_s_next;
  logic [2:0] tx_n_reg, tx_n_next;
  logic [7:0] tx_b_reg, tx_b_next;
  logic [3:0] tx_dbits_reg, tx_dbits_next;
  par_t       tx_par_reg, tx_par_next;
  logic       tx_stop2_reg, tx_stop2_next;
  logic       tx_second_reg, tx_second_next;
  logic       tx_pbit_reg, tx_pbit_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_reg  <= ST_IDLE;
      tx_s_reg      <= '0;
      tx_n_reg      <= '0;
      tx_b_reg      <= '0;
      tx_dbits_reg  <= DBITS_8;
      tx_par_reg    <= PAR_NONE;
      tx_stop2_reg  <= 1'b0;
      tx_second_reg <= 1'b0;
      tx_pbit_reg   <= 1'b0;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_s_reg      <= tx_s_next;
      tx_n_reg      <= tx_n_next;
      tx_b_reg      <= tx_b_next;
      tx_dbits_reg  <= tx_dbits_next;
      tx_par_reg    <= tx_par_next;
      tx_stop2_reg  <= tx_stop2_next;
      tx_second_reg <= tx_second_next;
      tx_pbit_reg   <= tx_pbit_next;
    end
  end

  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_s_next      = tx_s_reg;
    tx_n_next      = tx_n_reg;
    tx_b_next      = tx_b_reg;
    tx_dbits_next  = tx_dbits_reg;
    tx_par_next    = tx_par_reg;
    tx_stop2_next  = tx_stop2_reg;
    tx_second_next = tx_second_reg;
    tx_pbit_next   = tx_pbit_reg;
    case (tx_state_reg)
      ST_IDLE: begin
        // The head stays in the FIFO until the last stop bit has gone out.
        if (!tx_empty) begin
          tx_state_next  = ST_START;
          tx_s_next      = '0;
          tx_n_next      = '0;
          tx_b_next      = tx_ld_data;
          tx_dbits_next  = dbits_ld;
          tx_par_next    = par_eff;
          tx_stop2_next  = stop2;
          tx_second_next = 1'b0;
          tx_pbit_next   = tx_ld_pbit;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_state_next = ST_DATA;
            tx_s_next     = '0;
          end else begin
            tx_s_next = tx_s_reg + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_s_next = '0;
            tx_b_next = tx_b_reg >> 1;
            if (tx_n_reg == 3'(tx_dbits_reg - 4'd1))
              tx_state_next = (tx_par_reg != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              tx_n_next = tx_n_reg + 1'b1;
          end else begin
            tx_s_next = tx_s_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_state_next = ST_STOP;
            tx_s_next     = '0;
          end else begin
            tx_s_next = tx_s_reg + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tx_s_reg == S_LAST) begin
            tx_s_next = '0;
            if (tx_stop2_reg && !tx_second_reg) tx_second_next = 1'b1;
            else                                tx_state_next  = ST_IDLE;
          end else begin
            tx_s_next = tx_s_reg + 1'b1;
          end
        end
      end
      default: tx_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    tx_done = 1'b0;
    case (tx_state_reg)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = tx_b_reg[0];
      ST_PARITY: tx = tx_pbit_reg;
      ST_STOP: begin
        tx      = 1'b1;
        tx_done = tick && (tx_s_reg == S_LAST) && !(tx_stop2_reg && !tx_second_reg);
      end
      default:   tx = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  logic rx_meta_reg, rx_sync_reg, rx_prev_reg, rx_fall;
  assign rx_fall = rx_prev_reg & ~rx_sync_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
      rx_prev_reg <= rx_sync_reg;
    end
  end

  state_t     rx_state_reg, rx_state_next;
  logic [TW-1:0] rx_s_reg, rx_s_next;
  logic [2:0] rx_n_reg, rx_n_next;
  logic [7:0] rx_b_reg, rx_b_next;
  logic [3:0] rx_dbits_reg, rx_dbits_next;
  par_t       rx_par_reg, rx_par_next;
  logic       rx_stop2_reg, rx_stop2_next;
  logic       rx_second_reg, rx_second_next;
  logic       rx_perr_reg, rx_perr_next;
  logic       rx_ferr_reg, rx_ferr_next;
  logic       rx_done, rx_first_ferr, rx_full, rx_push, rx_par_exp;

  assign rx_par_exp = (^rx_b_reg) ^ (rx_par_reg == PAR_ODD);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state_reg  <= ST_IDLE;
      rx_s_reg      <= '0;
      rx_n_reg      <= '0;
      rx_b_reg      <= '0;
      rx_dbits_reg  <= DBITS_8;
      rx_par_reg    <= PAR_NONE;
      rx_stop2_reg  <= 1'b0;
      rx_second_reg <= 1'b0;
      rx_perr_reg   <= 1'b0;
      rx_ferr_reg   <= 1'b0;
    end else begin
      rx_state_reg  <= rx_state_next;
      rx_s_reg      <= rx_s_next;
      rx_n_reg      <= rx_n_next;
      rx_b_reg      <= rx_b_next;
      rx_dbits_reg  <= rx_dbits_next;
      rx_par_reg    <= rx_par_next;
      rx_stop2_reg  <= rx_stop2_next;
      rx_second_reg <= rx_second_next;
      rx_perr_reg   <= rx_perr_next;
      rx_ferr_reg   <= rx_ferr_next;
    end
  end

  always_comb begin
    rx_state_next  = rx_state_reg;
    rx_s_next      = rx_s_reg;
    rx_n_next      = rx_n_reg;
    rx_b_next      = rx_b_reg;
    rx_dbits_next  = rx_dbits_reg;
    rx_par_next    = rx_par_reg;
    rx_stop2_next  = rx_stop2_reg;
    rx_second_next = rx_second_reg;
    rx_perr_next   = rx_perr_reg;
    rx_ferr_next   = rx_first_ferr;
    case (rx_state_reg)
      ST_IDLE: begin
        if (rx_fall) begin
          rx_state_next  = ST_START;
          rx_s_next      = '0;
          rx_n_next      = '0;
          rx_b_next      = '0;
          rx_dbits_next  = dbits_ld;
          rx_par_next    = par_eff;
          rx_stop2_next  = stop2;
          rx_second_next = 1'b0;
          rx_perr_next   = 1'b0;
          rx_ferr_next   = 1'b0;
        end
      end
      ST_START: begin
        // Half a bit in: still low means a real start bit, high was a glitch.
        // Restarting the count here puts every later sample mid-bit.
        if (tick) begin
          if (rx_s_reg == S_HALF) begin
            rx_s_next     = '0;
            rx_state_next = rx_sync_reg ? ST_IDLE : ST_DATA;
          end else begin
            rx_s_next = rx_s_reg + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (rx_s_reg == S_LAST) begin
            rx_s_next           = '0;
            rx_b_next[rx_n_reg] = rx_sync_reg;
            if (rx_n_reg == 3'(rx_dbits_reg - 4'd1))
              rx_state_next = (rx_par_reg != PAR_NONE) ? ST_PARITY : ST_STOP;
            else
              rx_n_next = rx_n_reg + 1'b1;
          end else begin
            rx_s_next = rx_s_reg + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (rx_s_reg == S_LAST) begin
            rx_s_next     = '0;
            rx_perr_next  = (rx_sync_reg != rx_par_exp);
            rx_state_next = ST_STOP;
          end else begin
            rx_s_next = rx_s_reg + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (rx_s_reg == S_LAST) begin
            rx_s_next = '0;
            if (rx_stop2_reg && !rx_second_reg) rx_second_next = 1'b1;
            else                                rx_state_next  = ST_IDLE;
          end else begin
            rx_s_next = rx_s_reg + 1'b1;
          end
        end
      end
      default: rx_state_next = ST_IDLE;
    endcase
  end

  // Only the first stop bit is checked; a second stop bit merely delays
  // completion of the character.
  always_comb begin
    rx_done       = 1'b0;
    rx_first_ferr = rx_ferr_reg;
    if (rx_state_reg == ST_STOP && tick && rx_s_reg == S_LAST) begin
      if (!rx_second_reg) rx_first_ferr = ~rx_sync_reg;
      rx_done = !(rx_stop2_reg && !rx_second_reg);
    end
  end

  // A character completing into a full FIFO is dropped, not overwritten.
  assign rx_push = rx_done & ~rx_full;

  uart_cfg_fifo #(.WIDTH(8), .ADDR_W(FIFO_W)) u_rx_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (rx_push),
    .pop    (rd_uart),
    .w_data (rx_b_reg),
    .r_data (r_data),
    .empty  (rx_empty),
    .full   (rx_full),
    .level  (rx_level)
  );

  // ---------------- sticky error flags (set beats clear) ----------------
  logic frame_err_reg, overrun_err_reg;
  assign frame_err   = frame_err_reg;
  assign overrun_err = overrun_err_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
      overrun_err_reg <= 1'b0;
    end else begin
      if (rx_done && rx_perr_reg)   parity_err_reg  <= 1'b1;
      else if (clr_err)             parity_err_reg  <= 1'b0;
      if (rx_done && rx_first_ferr) frame_err_reg   <= 1'b1;
      else if (clr_err)             frame_err_reg   <= 1'b0;
      if (rx_done && rx_full)       overrun_err_reg <= 1'b1;
      else if (clr_err)             overrun_err_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg -- directed self-checking bench for uart_cfg (FIFO_W=2, dvsr=0,
// so one bit lasts 16 clocks). Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_uart_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic [20:0] dvsr;
  logic [1:0]  dbit_sel, par_sel;
  logic        stop2, rx, rd_uart, wr_uart, clr_err;
  logic [7:0]  w_data;
  logic        tx;
  logic [7:0]  r_data;
  logic        rx_empty, tx_full;
  logic [2:0]  rx_level, tx_level;
  logic        parity_err, frame_err, overrun_err;

  int checks = 0;
  int errors = 0;

  uart_cfg #(.FIFO_W(2), .SB_TICK(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .dvsr        (dvsr),
    .dbit_sel    (dbit_sel),
    .par_sel     (par_sel),
    .stop2       (stop2),
    .rx          (rx),
    .rd_uart     (rd_uart),
    .wr_uart     (wr_uart),
    .w_data      (w_data),
    .clr_err     (clr_err),
    .tx          (tx),
    .r_data      (r_data),
    .rx_empty    (rx_empty),
    .tx_full     (tx_full),
    .rx_level    (rx_level),
    .tx_level    (tx_level),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one serial frame on rx, 16 clocks per bit, then 4 idle clocks.
  task automatic send_rx(input logic [7:0] d, input int nbits, input bit use_par,
                         input bit pbit, input bit stop_val, input int nstop);
    rx = 1'b0;
    wait_clk(16);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      wait_clk(16);
    end
    if (use_par) begin
      rx = pbit;
      wait_clk(16);
    end
    for (int i = 0; i < nstop; i++) begin
      rx = (i == 0) ? stop_val : 1'b1;
      wait_clk(16);
    end
    rx = 1'b1;
    wait_clk(4);
    $display("rx frame sent: data=%h bits=%0d par=%0d pbit=%0d stop=%0d nstop=%0d",
             d, nbits, use_par, pbit, stop_val, nstop);
  endtask

  task automatic pop_rx();
    rd_uart = 1'b1;
    wait_clk(1);
    rd_uart = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; dvsr = '0; dbit_sel = 2'b11; par_sel = 2'b00; stop2 = 1'b0;
    rx = 1'b1; rd_uart = 1'b0; wr_uart = 1'b0; w_data = '0; clr_err = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);
    checks++; if (tx !== 1'b1)        begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (rx_empty !== 1'b1)  begin errors++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
    checks++; if (tx_full !== 1'b0)   begin errors++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
    checks++; if (rx_level !== 3'd0)  begin errors++; $display("FAIL reset_rx_level: got %0d want 0", rx_level); end
    checks++; if (tx_level !== 3'd0)  begin errors++; $display("FAIL reset_tx_level: got %0d want 0", tx_level); end
    checks++; if (r_data !== 8'h00)   begin errors++; $display("FAIL reset_r_data: got %h want 00", r_data); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL reset_overrun_err: got %b want 0", overrun_err); end
    $display("test_reset done");
  endtask

  task automatic test_tx_8n1();
    logic [9:0] exp_bits;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    dbit_sel = 2'b11; par_sel = 2'b00; stop2 = 1'b0;
    wr_uart = 1'b1; w_data = 8'hA5;
    wait_clk(1);
    wr_uart = 1'b0;
    checks++; if (tx_level !== 3'd1) begin errors++; $display("FAIL tx_level_after_write: got %0d want 1", tx_level); end
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL tx_idle_before_start: got %b want 1", tx); end
    wait_clk(1);
    checks++; if (tx !== 1'b0)       begin errors++; $display("FAIL tx_start_edge: got %b want 0", tx); end
    // Format changes mid-frame must not disturb this frame.
    dbit_sel = 2'b00; par_sel = 2'b01; stop2 = 1'b1;
    wait_clk(8);
    for (int b = 0; b < 10; b++) begin
      checks++;
      if (tx !== exp_bits[b]) begin
        errors++; $display("FAIL tx_bit%0d: got %b want %b", b, tx, exp_bits[b]);
      end
      if (b < 9) wait_clk(16);
    end
    wait_clk(7);
    checks++; if (tx_level !== 3'd1) begin errors++; $display("FAIL tx_level_before_stop_end: got %0d want 1", tx_level); end
    wait_clk(1);
    checks++; if (tx_level !== 3'd0) begin errors++; $display("FAIL tx_level_after_stop_end: got %0d want 0", tx_level); end
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL tx_idle_after_frame: got %b want 1", tx); end
    dbit_sel = 2'b11; par_sel = 2'b00; stop2 = 1'b0;
    wait_clk(20);
    $display("test_tx_8n1 done");
  endtask

  task automatic test_rx_7e2();
    dbit_sel = 2'b10; par_sel = 2'b01; stop2 = 1'b1;
`ifdef UART_CFG_PARITY_EN
    send_rx(8'h41, 7, 1'b1, 1'b0, 1'b1, 2);
`else
    send_rx(8'h41, 7, 1'b0, 1'b0, 1'b1, 2);
`endif
    checks++; if (r_data !== 8'h41)    begin errors++; $display("FAIL rx7_data: got %h want 41", r_data); end
    checks++; if (rx_level !== 3'd1)   begin errors++; $display("FAIL rx7_level: got %0d want 1", rx_level); end
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rx7_parity_ok: got %b want 0", parity_err); end
    checks++; if (frame_err !== 1'b0)  begin errors++; $display("FAIL rx7_frame_ok: got %b want 0", frame_err); end
    pop_rx();
    checks++; if (rx_empty !== 1'b1)   begin errors++; $display("FAIL rx7_empty_after_pop: got %b want 1", rx_empty); end
`ifdef UART_CFG_PARITY_EN
    send_rx(8'h41, 7, 1'b1, 1'b1, 1'b1, 2);
    checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL rx7_parity_bad: got %b want 1", parity_err); end
    checks++; if (r_data !== 8'h41)    begin errors++; $display("FAIL rx7_bad_par_data: got %h want 41", r_data); end
    pop_rx();
    clr_err = 1'b1; wait_clk(1); clr_err = 1'b0;
    checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rx7_parity_clear: got %b want 0", parity_err); end
`endif
    dbit_sel = 2'b11; par_sel = 2'b00; stop2 = 1'b0;
    $display("test_rx_7e2 done");
  endtask

  task automatic test_frame_err();
    send_rx(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_err_set: got %b want 1", frame_err); end
    checks++; if (rx_level !== 3'd1)  begin errors++; $display("FAIL frame_err_level: got %0d want 1", rx_level); end
    checks++; if (r_data !== 8'h3C)   begin errors++; $display("FAIL frame_err_data: got %h want 3c", r_data); end
    clr_err = 1'b1; wait_clk(1); clr_err = 1'b0;
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_err_clear: got %b want 0", frame_err); end
    pop_rx();
    checks++; if (rx_empty !== 1'b1)  begin errors++; $display("FAIL frame_err_pop: got %b want 1", rx_empty); end
    $display("test_frame_err done");
  endtask

  task automatic test_overrun();
    logic [7:0] chars [5];
    chars = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) send_rx(chars[i], 8, 1'b0, 1'b0, 1'b1, 1);
    checks++; if (rx_level !== 3'd4)    begin errors++; $display("FAIL overrun_level: got %0d want 4", rx_level); end
    checks++; if (overrun_err !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b want 1", overrun_err); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (r_data !== chars[i]) begin
        errors++; $display("FAIL overrun_read%0d: got %h want %h", i, r_data, chars[i]);
      end
      pop_rx();
    end
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL overrun_drained: got %b want 1", rx_empty); end
    pop_rx();
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL pop_when_empty: got %0d want 0", rx_level); end
    clr_err = 1'b1; wait_clk(1); clr_err = 1'b0;
    checks++; if (overrun_err !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun_err); end
    $display("test_overrun done");
  endtask

  task automatic test_glitch();
    rx = 1'b0; wait_clk(4); rx = 1'b1; wait_clk(40);
    checks++; if (rx_empty !== 1'b1) begin errors++; $display("FAIL glitch_empty: got %b want 1", rx_empty); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL glitch_level: got %0d want 0", rx_level); end
    send_rx(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1);
    checks++; if (r_data !== 8'h5A)  begin errors++; $display("FAIL glitch_recover_data: got %h want 5a", r_data); end
    pop_rx();
    $display("test_glitch done");
  endtask

  task automatic test_tx_full_reset();
    wr_uart = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w_data = 8'(i + 1);
      wait_clk(1);
    end
    wr_uart = 1'b0;
    checks++; if (tx_level !== 3'd4) begin errors++; $display("FAIL txfull_level: got %0d want 4", tx_level); end
    checks++; if (tx_full !== 1'b1)  begin errors++; $display("FAIL txfull_flag: got %b want 1", tx_full); end
    checks++; if (tx !== 1'b0)       begin errors++; $display("FAIL txfull_in_start: got %b want 0", tx); end
    reset = 1'b1;
    wait_clk(1);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL midreset_tx: got %b want 1", tx); end
    checks++; if (tx_level !== 3'd0) begin errors++; $display("FAIL midreset_tx_level: got %0d want 0", tx_level); end
    checks++; if (tx_full !== 1'b0)  begin errors++; $display("FAIL midreset_tx_full: got %b want 0", tx_full); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL midreset_rx_level: got %0d want 0", rx_level); end
    reset = 1'b0;
    wait_clk(20);
    checks++; if (tx !== 1'b1)       begin errors++; $display("FAIL postreset_tx_idle: got %b want 1", tx); end
    $display("test_tx_full_reset done");
  endtask

  initial begin
    test_reset();
    test_tx_8n1();
    test_rx_7e2();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_tx_full_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
